led_matrix_scan: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 53 +++++
 rtl/led_row_timer.sv | 53 +++++
 rtl/led_matrix_scan.sv | 125 ++++++++++++
 tb/tb_led_matrix_scan.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner: scan counter type,
// row index width and the 7-segment digit encoder.
package led_matrix_pkg;

  typedef logic [15:0] scan_cnt_t;

  // Segment order is a..g on bits 6..0.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic int row_idx_w(input int rows);
    return (rows > 2) ? $clog2(rows) : 1;
  endfunction

  // Bit 4 of the pattern drives the decimal point on bit 0.
  function automatic logic [7:0] encode_7seg(input logic [4:0] pattern);
    logic [6:0] seg;
    case (pattern[3:0])
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return {seg, pattern[4]};
  endfunction

endpackage

// File: rtl/led_row_timer.sv
// Row slot timer: counts clocks within a slot, steps the active row and
// decodes the lit window between the leading and trailing blanking gaps.
module led_row_timer
  import led_matrix_pkg::*;
#(
  parameter int ROWS    = 9,
  parameter int PERIOD  = 27000,
  parameter int GAP_ON  = 100,
  parameter int GAP_OFF = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       blank,
  output logic [row_idx_w(ROWS)-1:0] row_index,
  output logic [row_idx_w(ROWS)-1:0] next_row,
  output logic                       row_end,
  output logic                       frame_start,
  output logic                       on
);

  localparam int        RW        = row_idx_w(ROWS);
  localparam scan_cnt_t CNT_LAST  = scan_cnt_t'(PERIOD - 1);
  localparam scan_cnt_t ON_START  = scan_cnt_t'(GAP_ON);
  localparam scan_cnt_t ON_END    = scan_cnt_t'(PERIOD - GAP_OFF);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  scan_cnt_t cnt;
  logic      frame_q;

  assign row_end  = (cnt == CNT_LAST);
  assign next_row = (row_index == ROW_LAST) ? '0 : row_index + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      row_index <= '0;
      frame_q   <= 1'b1;
    end else begin
      cnt     <= row_end ? '0 : cnt + 16'd1;
      frame_q <= row_end && (next_row == '0);
      if (row_end) begin
        row_index <= next_row;
      end
    end
  end

  // The register is preset during reset so the pulse lands on the first
  // post-reset cycle; the gate keeps it quiet while reset is still held.
  assign frame_start = frame_q && !rst;

  assign on = (cnt >= ON_START) && (cnt < ON_END) && !blank;

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed LED matrix driver with a row framebuffer and per-slot
// column latch. Define LED_MATRIX_SCAN_7SEG_EN for per-row 7-segment decode.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS    = 9,
  parameter int COLS    = 8,
  parameter int PERIOD  = 27000,
  parameter int GAP_ON  = 100,
  parameter int GAP_OFF = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [row_idx_w(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]            wr_data,
`ifdef LED_MATRIX_SCAN_7SEG_EN
  input  logic                       wr_mode,
`endif
  input  logic [row_idx_w(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]            rd_data,
  input  logic                       blank,
  output logic [ROWS-1:0]            led_row,
  output logic [COLS-1:0]            led_col,
  output logic [row_idx_w(ROWS)-1:0] row_index,
  output logic                       frame_start
);

  localparam int RW = row_idx_w(ROWS);

  if (GAP_ON + GAP_OFF >= PERIOD) begin : g_bad_gaps
    $error("led_matrix_scan: GAP_ON + GAP_OFF must be less than PERIOD");
  end
  if (ROWS < 2 || ROWS > 16 || COLS < 1 || COLS > 16) begin : g_bad_size
    $error("led_matrix_scan: ROWS must be 2..16 and COLS 1..16");
  end
  if (PERIOD < 1 || PERIOD > 65535) begin : g_bad_period
    $error("led_matrix_scan: PERIOD must fit the 16-bit scan counter");
  end
`ifdef LED_MATRIX_SCAN_7SEG_EN
  if (COLS != 8) begin : g_bad_cols
    $error("led_matrix_scan: 7-segment mode needs COLS == 8");
  end
`endif

  logic [RW-1:0]   next_row;
  logic            row_end;
  logic            on;
  logic            wr_ok;
  logic            wr_hits_latch;
  logic [COLS-1:0] fb [ROWS];
  logic [COLS-1:0] col_q;
  logic [COLS-1:0] col_disp;

  led_row_timer #(
    .ROWS    (ROWS),
    .PERIOD  (PERIOD),
    .GAP_ON  (GAP_ON),
    .GAP_OFF (GAP_OFF)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .blank       (blank),
    .row_index   (row_index),
    .next_row    (next_row),
    .row_end     (row_end),
    .frame_start (frame_start),
    .on          (on)
  );

  assign wr_ok         = wr && (int'(wr_row) < ROWS);
  assign wr_hits_latch = wr_ok && (wr_row == next_row);

  // Column data is only captured at the slot boundary, so a write never
  // tears a row that is currently being displayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        fb[i] <= '0;
      end
      col_q <= '0;
    end else begin
      if (wr_ok) begin
        fb[wr_row] <= wr_data;
      end
      if (row_end) begin
        col_q <= wr_hits_latch ? wr_data : fb[next_row];
      end
    end
  end

`ifdef LED_MATRIX_SCAN_7SEG_EN
  logic [ROWS-1:0] fb_mode;
  logic            mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_mode <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        fb_mode[wr_row] <= wr_mode;
      end
      if (row_end) begin
        mode_q <= wr_hits_latch ? wr_mode : fb_mode[next_row];
      end
    end
  end

  assign col_disp = mode_q ? encode_7seg(col_q[4:0]) : col_q;
`else
  assign col_disp = col_q;
`endif

  always_comb begin
    rd_data = '0;
    if (int'(rd_row) < ROWS) begin
      rd_data = fb[rd_row];
    end
  end

  assign led_row = ~({{(ROWS-1){1'b0}}, on} << row_index);
  assign led_col = on ? col_disp : '0;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with a 3-row, 20-clock slot geometry.
// Define LED_MATRIX_SCAN_7SEG_EN to also exercise the 7-segment rows.
module tb_led_matrix_scan;

  localparam int ROWS    = 3;
  localparam int COLS    = 8;
  localparam int PERIOD  = 20;
  localparam int GAP_ON  = 2;
  localparam int GAP_OFF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [1:0] wr_row;
  logic [7:0] wr_data;
  logic [1:0] rd_row;
  logic [7:0] rd_data;
  logic       blank;
  logic [2:0] led_row;
  logic [7:0] led_col;
  logic [1:0] row_index;
  logic       frame_start;
`ifdef LED_MATRIX_SCAN_7SEG_EN
  logic       wr_mode;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  always #5 clk = ~clk;

  // Bench-owned cycle count since the last reset edge; slot phase and row
  // are derived from it independently of the DUT.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .PERIOD(PERIOD), .GAP_ON(GAP_ON), .GAP_OFF(GAP_OFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
`ifdef LED_MATRIX_SCAN_7SEG_EN
    .wr_mode     (wr_mode),
`endif
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .blank       (blank),
    .led_row     (led_row),
    .led_col     (led_col),
    .row_index   (row_index),
    .frame_start (frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int ph, input int rw);
    int n = 0;
    while (!(((cyc % PERIOD) == ph) && (((cyc / PERIOD) % ROWS) == rw))) begin
      if (n >= 200) begin
        n_checks++;
        $display("FAIL goto: timeout waiting for phase %0d row %0d (cyc=%0d)", ph, rw, cyc);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic write_row(input logic [1:0] r, input logic [7:0] d);
    wr      = 1'b1;
    wr_row  = r;
    wr_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; wr_row = '0; wr_data = '0; rd_row = '0; blank = 1'b0;
`ifdef LED_MATRIX_SCAN_7SEG_EN
    wr_mode = 1'b0;
`endif
    repeat (3) begin
      tick();
      n_checks++;
      if ({led_row, led_col, frame_start} !== {3'b111, 8'h00, 1'b0})
        $display("FAIL reset_outputs: got row=%b col=%h fs=%b, want row=111 col=00 fs=0",
                 led_row, led_col, frame_start);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({frame_start, row_index} !== {1'b1, 2'd0})
      $display("FAIL first_frame_start: got fs=%b row_index=%0d, want fs=1 row_index=0",
               frame_start, row_index);
    else n_pass++;
    tick();
    n_checks++;
    if (frame_start !== 1'b0)
      $display("FAIL frame_start_pulse: got %b one cycle later, want 0", frame_start);
    else n_pass++;
    repeat (59) tick();
    n_checks++;
    if (frame_start !== 1'b1)
      $display("FAIL second_frame_start: got %b at 60 cycles, want 1", frame_start);
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [10:0] exp;
    write_row(2'd0, 8'hA5);
    write_row(2'd1, 8'h3C);
    write_row(2'd2, 8'hFF);
    goto(0, 1);
    for (int p = 0; p < PERIOD; p++) begin
      exp = (p >= GAP_ON && p < PERIOD - GAP_OFF) ? {3'b101, 8'h3C} : {3'b111, 8'h00};
      n_checks++;
      if ({led_row, led_col} !== exp || row_index !== 2'd1)
        $display("FAIL scan_row1 p=%0d: got row=%b col=%h idx=%0d, want row=%b col=%h idx=1",
                 p, led_row, led_col, row_index, exp[10:8], exp[7:0]);
      else n_pass++;
      tick();
    end
    goto(5, 2);
    n_checks++;
    if ({led_row, led_col} !== {3'b011, 8'hFF})
      $display("FAIL scan_row2: got row=%b col=%h, want row=011 col=ff", led_row, led_col);
    else n_pass++;
    goto(5, 0);
    n_checks++;
    if ({led_row, led_col} !== {3'b110, 8'hA5})
      $display("FAIL scan_row0: got row=%b col=%h, want row=110 col=a5", led_row, led_col);
    else n_pass++;
  endtask

  task automatic test_bypass();
    goto(19, 0);
    write_row(2'd1, 8'h81);
    goto(2, 1);
    n_checks++;
    if ({led_row, led_col} !== {3'b101, 8'h81})
      $display("FAIL write_bypass: got row=%b col=%h, want row=101 col=81", led_row, led_col);
    else n_pass++;
    goto(5, 1);
    write_row(2'd1, 8'h42);
    goto(10, 1);
    n_checks++;
    if ({led_row, led_col} !== {3'b101, 8'h81})
      $display("FAIL no_tear: got row=%b col=%h, want row=101 col=81", led_row, led_col);
    else n_pass++;
    goto(3, 1);
    n_checks++;
    if ({led_row, led_col} !== {3'b101, 8'h42})
      $display("FAIL next_frame_update: got row=%b col=%h, want row=101 col=42", led_row, led_col);
    else n_pass++;
  endtask

  task automatic test_readback_oor();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hA5; exp_rd[1] = 8'h42; exp_rd[2] = 8'hFF; exp_rd[3] = 8'h00;
    write_row(2'd3, 8'h55);
    for (int r = 0; r < 4; r++) begin
      rd_row = 2'(r);
      #1;
      n_checks++;
      if (rd_data !== exp_rd[r])
        $display("FAIL readback rd_row=%0d: got %h, want %h", r, rd_data, exp_rd[r]);
      else n_pass++;
    end
    wr = 1'b1; wr_row = 2'd2; wr_data = 8'h11; rd_row = 2'd2;
    #1;
    n_checks++;
    if (rd_data !== 8'hFF)
      $display("FAIL same_row_rd_old: got %h, want ff", rd_data);
    else n_pass++;
    tick();
    wr = 1'b0;
    n_checks++;
    if (rd_data !== 8'h11)
      $display("FAIL same_row_rd_new: got %h, want 11", rd_data);
    else n_pass++;
  endtask

  task automatic test_blank();
    goto(0, 2);
    blank = 1'b1;
    #1;
    for (int p = 0; p < PERIOD; p++) begin
      n_checks++;
      if ({led_row, led_col, row_index} !== {3'b111, 8'h00, 2'd2})
        $display("FAIL blank p=%0d: got row=%b col=%h idx=%0d, want row=111 col=00 idx=2",
                 p, led_row, led_col, row_index);
      else n_pass++;
      tick();
    end
    blank = 1'b0;
    #1;
    n_checks++;
    if ({frame_start, row_index} !== {1'b1, 2'd0})
      $display("FAIL blank_timing: got fs=%b idx=%0d, want fs=1 idx=0", frame_start, row_index);
    else n_pass++;
    goto(5, 0);
    n_checks++;
    if ({led_row, led_col} !== {3'b110, 8'hA5})
      $display("FAIL after_blank: got row=%b col=%h, want row=110 col=a5", led_row, led_col);
    else n_pass++;
  endtask

`ifdef LED_MATRIX_SCAN_7SEG_EN
  task automatic test_7seg();
    wr_mode = 1'b1;
    write_row(2'd0, 8'h13);
    wr_mode = 1'b0;
    goto(8, 0);
    n_checks++;
    if ({led_row, led_col} !== {3'b110, 8'hA5})
      $display("FAIL seg_no_tear: got row=%b col=%h, want row=110 col=a5", led_row, led_col);
    else n_pass++;
    goto(5, 1);
    goto(5, 0);
    n_checks++;
    if ({led_row, led_col} !== {3'b110, 8'b11110011})
      $display("FAIL seg_encode: got row=%b col=%b, want row=110 col=11110011", led_row, led_col);
    else n_pass++;
    rd_row = 2'd0;
    #1;
    n_checks++;
    if (rd_data !== 8'h13)
      $display("FAIL seg_readback: got %h, want 13", rd_data);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_bypass();
    test_readback_oor();
    test_blank();
`ifdef LED_MATRIX_SCAN_7SEG_EN
    test_7seg();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
